// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared defaults and types for the GPIO input filter
//
// Purpose: default pin count and counter width, the pin-vector type and the
//          per-pin filter state encoding used by gpio_filter_cell.
// Ports:   none (package).

package gpio_pkg;

    localparam int GPIO_NUM_DEFAULT = 32;
    localparam int GPIO_FILT_CNT_W  = 8;

    typedef logic [GPIO_NUM_DEFAULT-1:0] gpio_vec_t;

    // STABLE: synchronised sample agrees with the filtered level.
    // PENDING: sample differs and the debounce counter is running.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } filt_state_t;

endpackage

// File: rtl/gpio_filter_cell.sv
// rtl/gpio_filter_cell.sv - single-pin synchroniser, debounce counter and edge pulses
//
// Purpose: double-flop synchronises one pad, then only lets the filtered level
//          follow the sample once it has differed for s_threshold consecutive
//          clocks. Emits registered one-cycle rise/fall pulses one cycle after
//          the filtered level changes.
// Ports:
//   clk          in   block clock, rising edge
//   resetn       in   synchronous active-low reset
//   pad          in   raw asynchronous pad level
//   s_threshold  in   effective threshold, must be >= 1 (top guarantees it)
//   filt         out  filtered level
//   rise         out  one-cycle pulse after filt goes 0->1
//   fall         out  one-cycle pulse after filt goes 1->0

module gpio_filter_cell
    import gpio_pkg::*;
#(
    parameter int CNT_WIDTH = GPIO_FILT_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pad,
    input  logic [CNT_WIDTH-1:0] s_threshold,
    output logic                 filt,
    output logic                 rise,
    output logic                 fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 sync0;
    logic                 sync1;
    logic                 filt_q;
    logic                 filt_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 rise_q;
    logic                 fall_q;

    filt_state_t          state;
    logic                 filt_next;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            filt_q <= 1'b0;
            filt_d <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync0  <= pad;
            sync1  <= sync0;
            filt_q <= filt_next;
            cnt_q  <= cnt_next;
            // filt_d holds the previous filtered level so the pulses land one
            // cycle after filt itself changes.
            filt_d <= filt_q;
            rise_q <= filt_q & ~filt_d;
            fall_q <= ~filt_q & filt_d;
        end
    end

    // The state is implied by sample vs. filtered level; no extra flop needed.
    always_comb begin
        state     = (sync1 != filt_q) ? ST_PENDING : ST_STABLE;
        filt_next = filt_q;
        cnt_next  = '0;
        case (state)
            ST_STABLE: begin
                // Any return to the filtered level throws away partial credit.
                cnt_next = '0;
            end
            ST_PENDING: begin
                // >= so a threshold lowered below the running count still
                // completes on this cycle, and the count can never wrap.
                if (cnt_q >= s_threshold - CNT_ONE) begin
                    filt_next = sync1;
                    cnt_next  = '0;
                end else begin
                    cnt_next = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    assign filt = filt_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/gpio_input_filter.sv
// rtl/gpio_input_filter.sv - per-pin pad synchroniser and glitch filter for gpio_in
//
// Purpose: instantiates one gpio_filter_cell per pin and computes each pin's
//          effective threshold (bypass or zero threshold both mean 1).
// Ports:
//   HCLK           in   block clock, rising edge
//   HRESETn        in   synchronous active-low reset
//   pad_in         in   raw asynchronous pad levels
//   cfg_enable     in   per-pin filter enable, 0 = bypass
//   cfg_threshold  in   shared consecutive-sample requirement, 0 acts as 1
//   gpio_in_filt   out  filtered levels to the GPIO peripheral
//   rise_pulse     out  one-cycle pulse per pin on filtered 0->1
//   fall_pulse     out  one-cycle pulse per pin on filtered 1->0

module gpio_input_filter
    import gpio_pkg::*;
#(
    parameter int NUM_GPIO  = GPIO_NUM_DEFAULT,
    parameter int CNT_WIDTH = GPIO_FILT_CNT_W
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_GPIO-1:0]  pad_in,
    input  logic [NUM_GPIO-1:0]  cfg_enable,
    input  logic [CNT_WIDTH-1:0] cfg_threshold,
    output logic [NUM_GPIO-1:0]  gpio_in_filt,
    output logic [NUM_GPIO-1:0]  rise_pulse,
    output logic [NUM_GPIO-1:0]  fall_pulse
);

    localparam logic [CNT_WIDTH-1:0] THR_ONE = CNT_WIDTH'(1);

    logic thr_zero;
    assign thr_zero = (cfg_threshold == '0);

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] eff_thr;

        // Applied combinationally so an enable change mid-count takes effect
        // on the very next edge.
        assign eff_thr = (cfg_enable[i] && !thr_zero) ? cfg_threshold : THR_ONE;

        gpio_filter_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .clk         (HCLK),
            .resetn      (HRESETn),
            .pad         (pad_in[i]),
            .s_threshold (eff_thr),
            .filt        (gpio_in_filt[i]),
            .rise        (rise_pulse[i]),
            .fall        (fall_pulse[i])
        );
    end

endmodule

// File: doc/gpio_input_filter.md
# gpio_input_filter

Per-pin input synchroniser and glitch filter between the chip pads and the GPIO peripheral's `gpio_in` bus. Each pad input is double-flop synchronised, then must hold a new level for a configurable number of consecutive clocks before the filtered output follows it. The block also emits one-cycle rise/fall pulses on every filtered transition. Its output feeds the GPIO peripheral directly, giving that peripheral's edge and level interrupt logic debounced inputs.

## Interface
- `NUM_GPIO`, 32, number of pins filtered
- `CNT_WIDTH`, 8, width of the per-pin debounce counter and threshold
- `HCLK`  in  1  block clock; all state on rising edge
- `HRESETn`  in  1  reset; synchronous, active-low
- `pad_in`  in  NUM_GPIO  raw asynchronous pad levels
- `cfg_enable`  in  NUM_GPIO  per-pin filter enable; 0 = bypass (threshold forced to 1)
- `cfg_threshold`  in  CNT_WIDTH  required consecutive stable samples, shared by all pins; 0 treated as 1
- `gpio_in_filt`  out  NUM_GPIO  filtered levels, to GPIO `gpio_in`
- `rise_pulse`  out  NUM_GPIO  1-cycle pulse, filtered 0->1
- `fall_pulse`  out  NUM_GPIO  1-cycle pulse, filtered 1->0

## Operation
- Sync stage per pin: `sync0 <= pad_in`, `sync1 <= sync0`. `sync1` is the sample `s`.
- Effective threshold per pin: `T = (cfg_enable[i] && cfg_threshold != 0) ? cfg_threshold : 1`.
- Per-pin state is the filtered level `filt` and counter `cnt`. The state machine has two states:
  - STABLE (`s == filt`): `cnt <= 0`.
  - PENDING (`s != filt`):
    - if `cnt >= T-1`: `filt <= s`, `cnt <= 0`.
    - otherwise: `cnt <= cnt + 1`.
- Glitch rejection: a sample that returns to `filt` before the count completes clears `cnt`. No partial credit is kept.
- Use `>=`, not `==`. If the threshold is lowered mid-count below the current `cnt`, the update happens on the next PENDING cycle. The counter never wraps.
- `rise_pulse[i]` and `fall_pulse[i]` are registered. They assert on the cycle after `filt` changes, for exactly one cycle; they are derived from the old and new values of `filt`.
- Pins are fully independent. The only shared state is `cfg_threshold`.

## Timing
- Reset (`HRESETn` low at a clock edge):
  - `sync0`, `sync1`, `filt`, `cnt` and both pulse registers clear to 0.
  - Outputs read 0 from the cycle after that edge.
  - Reset asserted mid-count discards the count; no pulse is generated by reset itself.
- Latency, pad change to `gpio_in_filt`: 2 + T clock edges. This includes bypass (T=1: 3 edges).
- Pulse outputs lag `gpio_in_filt` by 1 cycle.
- A pad that toggles at least every T-1 sampled cycles never propagates.
- A pin whose `cfg_enable` is toggled mid-count uses the new T immediately.
- Maximum T is 2^CNT_WIDTH-1. `cnt` needs only CNT_WIDTH bits.

## Structure
- Package `gpio_pkg` holds:
  - the defaults `GPIO_NUM_DEFAULT = 32` and `GPIO_FILT_CNT_W = 8`;
  - the typedef `gpio_vec_t` (logic [NUM_GPIO-1:0] equivalent for the default).
- Sub-module `gpio_filter_cell`: one pin. It contains the sync flops, counter, `filt` and pulse registers, and takes `s_threshold` as input. The top level generates NUM_GPIO instances and computes the effective threshold per pin.

## Test plan
- Reset: drive `pad_in = 0xFFFFFFFF` with `HRESETn = 0` for 5 cycles -> all outputs 0 throughout. After release, `gpio_in_filt = 0xFFFFFFFF` exactly 2+T edges later.
- Threshold 4, pin 3 held high -> `gpio_in_filt[3]` rises on edge 6 after the pad change. `rise_pulse[3]` is high for exactly one cycle, on edge 7.
- Threshold 4, pin 5 pulsed high for 3 cycles then low -> `gpio_in_filt[5]` stays 0 and no pulses occur. A following 4-cycle pulse propagates.
- Bypass: `cfg_enable[7] = 0`, threshold 200 -> pin 7 follows the pad with 3-edge latency. Pin 8 (enabled) still needs 202 edges.
- Threshold 0 behaves as 1. Threshold lowered from 10 to 2 while `cnt = 6` -> `filt` updates on the next edge.
- Synchronous reset asserted mid-count at threshold 8 (`cnt = 5`) -> after release with the pad still high, 2+8 further edges are needed. No stray `fall_pulse` or `rise_pulse` occurs around reset.
